corr_peak_detect: RTL and testbench

Windowed peak finder placed directly downstream of the pipelined CORDIC magnitude stage in the cross-correlation datapath. Consumes one magnitude sample per valid cycle, tracks the maximum and its index over a fixed-length correlation window, and reports peak value and lag once per window. Output feeds the lag/alignment decision logic.

---
 rtl/corr_pkg.sv | 21 ++
 rtl/corr_win_ctr.sv | 31 +++
 rtl/corr_peak_detect.sv | 96 +++++++++
 tb/tb_corr_peak_detect.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared defaults, FSM state type and clog2 helper for corr_peak_detect
package corr_pkg;

  localparam int MAG_W_DEF = 20;
  localparam int LEN_DEF   = 1024;

  typedef enum logic [0:0] {
    FIRST = 1'b0,
    SCAN  = 1'b1
  } corr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/corr_win_ctr.sv
// rtl/corr_win_ctr.sv - window sample counter wrapping at LEN with clear and last-sample flag
module corr_win_ctr
  import corr_pkg::*;
#(
  parameter int LEN   = LEN_DEF,
  parameter int IDX_W = clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] count,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  assign last = (count == LAST_IDX);

  // A sample arriving with clear becomes index 0, so the next index is 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? IDX_W'(1) : '0;
    end else if (inc) begin
      count <= last ? '0 : count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/corr_peak_detect.sv
// rtl/corr_peak_detect.sv - windowed magnitude peak finder; CORR_PEAK_THRESH_EN adds thresh/detect
module corr_peak_detect
  import corr_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int IDX_W = clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [MAG_W-1:0] mag,
`ifdef CORR_PEAK_THRESH_EN
  input  logic [MAG_W-1:0] thresh,
  output logic             detect,
`endif
  output logic             peak_valid,
  output logic [MAG_W-1:0] peak_mag,
  output logic [IDX_W-1:0] peak_idx,
  output logic             busy
);

  corr_state_e      state;
  logic [MAG_W-1:0] cur_mag;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] count;
  logic             last;
  logic             take_first;
  logic             beats;
  logic             done;
  logic [MAG_W-1:0] final_mag;
  logic [IDX_W-1:0] final_idx;

  corr_win_ctr #(
    .LEN   (LEN),
    .IDX_W (IDX_W)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (in_valid),
    .count (count),
    .last  (last)
  );

  assign busy       = (count != '0);
  assign take_first = clear || (state == FIRST);
  assign beats      = (mag > cur_mag);
  assign done       = in_valid && !take_first && last;
  // The closing sample may itself be the peak, so results see the final compare.
  assign final_mag  = beats ? mag : cur_mag;
  assign final_idx  = beats ? count : cur_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FIRST;
      cur_mag    <= '0;
      cur_idx    <= '0;
      peak_valid <= 1'b0;
      peak_mag   <= '0;
      peak_idx   <= '0;
    end else begin
      peak_valid <= done;
      if (in_valid) begin
        if (take_first) begin
          cur_mag <= mag;
          cur_idx <= '0;
          state   <= SCAN;
        end else if (last) begin
          state <= FIRST;
        end else if (beats) begin
          cur_mag <= mag;
          cur_idx <= count;
        end
      end else if (clear) begin
        state <= FIRST;
      end
      if (done) begin
        peak_mag <= final_mag;
        peak_idx <= final_idx;
      end
    end
  end

`ifdef CORR_PEAK_THRESH_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      detect <= 1'b0;
    end else if (done) begin
      detect <= (final_mag >= thresh);
    end
  end
`endif

endmodule

// File: tb/tb_corr_peak_detect.sv
// tb/tb_corr_peak_detect.sv - scoreboard bench for corr_peak_detect with LEN=8
module tb_corr_peak_detect;

  localparam int MAG_W = 20;
  localparam int LEN   = 8;
  localparam int IDX_W = 3;
  localparam int THR   = 60;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [MAG_W-1:0] mag = '0;
  logic             peak_valid;
  logic [MAG_W-1:0] peak_mag;
  logic [IDX_W-1:0] peak_idx;
  logic             busy;
`ifdef CORR_PEAK_THRESH_EN
  logic [MAG_W-1:0] thresh = MAG_W'(THR);
  logic             detect;
`endif

  corr_peak_detect #(
    .MAG_W (MAG_W),
    .LEN   (LEN),
    .IDX_W (IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .mag        (mag),
`ifdef CORR_PEAK_THRESH_EN
    .thresh     (thresh),
    .detect     (detect),
`endif
    .peak_valid (peak_valid),
    .peak_mag   (peak_mag),
    .peak_idx   (peak_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int i;
    int d;
  } exp_t;

  exp_t q[$];
  int   pulse_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int m, input int i);
    exp_t e;
    e.m = m;
    e.i = i;
    e.d = (m >= THR) ? 1 : 0;
    q.push_back(e);
  endtask

  // Monitor: every peak_valid pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst && peak_valid) begin
      n_pulse++;
      pulse_cyc.push_back(cyc);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("peak_mag", int'(peak_mag), e.m);
        chk("peak_idx", int'(peak_idx), e.i);
`ifdef CORR_PEAK_THRESH_EN
        chk("detect", int'(detect), e.d);
`endif
      end
    end
  end

  task automatic send(input int v, input int gap);
    in_valid = 1'b1;
    mag = MAG_W'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_win(input int v[8]);
    for (int k = 0; k < 8; k++) send(v[k], 0);
  endtask

  int w1[8] = '{3, 9, 2, 9, 1, 0, 4, 5};
  int w2[8] = '{0, 0, 0, 0, 0, 0, 0, 100};
  int wa[8] = '{10, 0, 50, 0, 7, 0, 0, 0};
  int wb[8] = '{0, 1, 2, 3, 4, 5, 70, 6};
  int wf[8] = '{1, 2, 3, 4, 33, 5, 6, 7};
  int w59[8] = '{5, 59, 1, 2, 3, 4, 5, 6};
  int w60[8] = '{5, 1, 2, 60, 3, 4, 5, 6};
  int wz[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int p0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_peak_valid", int'(peak_valid), 0);
    chk("rst_peak_mag", int'(peak_mag), 0);
    chk("rst_peak_idx", int'(peak_idx), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous window, tie keeps earliest index
    push_exp(9, 1);
    send_win(w1);
    chk("latency_pulse", int'(peak_valid), 1);
    @(posedge clk);
    #1;
    chk("pulse_one_cycle", int'(peak_valid), 0);

    // Peak in the last sample
    push_exp(100, 7);
    send_win(w2);
    repeat (2) @(posedge clk);
    #1;

    // Same data as first window with gaps 0..3
    p0 = n_pulse;
    push_exp(9, 1);
    for (int k = 0; k < 8; k++) begin
      send(w1[k], k % 4);
      if (k < 7) chk("gap_busy", int'(busy), 1);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("gap_busy_end", int'(busy), 0);
    chk("gap_one_pulse", n_pulse - p0, 1);

    // Back-to-back windows
    pulse_cyc.delete();
    push_exp(50, 2);
    push_exp(70, 6);
    send_win(wa);
    for (int k = 0; k < 8; k++) begin
      send(wb[k], 0);
      if (k == 3) begin
        @(negedge clk);
        chk("hold_mag", int'(peak_mag), 50);
        chk("hold_idx", int'(peak_idx), 2);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    if (pulse_cyc.size() == 2) chk("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], 8);
    else chk("b2b_pulse_count", pulse_cyc.size(), 2);

    // Reset mid-window
    p0 = n_pulse;
    for (int k = 0; k < 5; k++) send(900 + k, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_mid_busy", int'(busy), 0);
    push_exp(33, 4);
    send_win(wf);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_one_pulse", n_pulse - p0, 1);

    // Clear coincident with a sample: that sample is index 0
    for (int k = 0; k < 3; k++) send(500, 0);
    push_exp(40, 0);
    clear = 1'b1;
    send(40, 0);
    for (int k = 1; k < 8; k++) send(k, 0);
    repeat (2) @(posedge clk);
    #1;

    // Threshold boundary windows and all-zero window
    push_exp(59, 1);
    send_win(w59);
    push_exp(60, 3);
    send_win(w60);
    push_exp(0, 0);
    send_win(wz);

    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
